// File: rtl/sha_padder.sv
// rtl/sha_padder.sv - SHA-2 message padder: 64-bit byte stream in, 512/1024-bit padded blocks out
// Optional feature macro: SHA_PADDER_SHA512_EN (enables 1024-bit SHA384/SHA512 blocks)
module sha_padder #(
    parameter int S_AXIS_DATA_WIDTH = 64,
    parameter int M_AXIS_DATA_WIDTH = 1024
) (
    input  logic                           axi_aclk,
    input  logic                           reset,
    input  logic [1:0]                     sha_type,
    input  logic [S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic [M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready
);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] EMIT  = 2'd1;
    localparam logic [1:0] EXTRA = 2'd2;

`ifdef SHA_PADDER_SHA512_EN
    localparam int NB = 128;
`else
    localparam int NB = 64;
`endif

    logic [1:0]  state;
    logic [7:0]  blk     [NB];
    logic [7:0]  nxt_blk [NB];
    logic [7:0]  xtr_blk [NB];
    logic [7:0]  off;
    logic [63:0] bit_cnt;
    logic        extra;
    logic        pad80;
    logic        in_msg;
    logic        mode_r;
    logic        tlast_r;

    logic        beat_mode;
    logic [3:0]  n;
    logic [63:0] new_len;
    int          bsz, lsz, xbsz, offi, ni;
    logic        fits80, fitlen, blk_full;
    logic [7:0]  dbyte  [8];
    logic [7:0]  lbyte  [8];
    logic [7:0]  xlbyte [8];
    logic        unused_ok;

    // mode is latched on the first beat of a message so later beats cannot switch it
`ifdef SHA_PADDER_SHA512_EN
    assign beat_mode = in_msg ? mode_r : sha_type[1];
`else
    assign beat_mode = 1'b0;
`endif
    assign unused_ok = &{1'b0, sha_type, in_msg};

    assign s_axis_tready = (state == FILL) && !reset;
    assign m_axis_tvalid = (state == EMIT);
    assign m_axis_tlast  = tlast_r;

    // next block contents for an accepted input beat, including padding on the tlast beat
    always_comb begin
        n = 4'd0;
        for (int k = 0; k < 8; k++) n = n + 4'(s_axis_tkeep[k]);
        new_len  = bit_cnt + {57'd0, n, 3'd0};
        bsz      = beat_mode ? 128 : 64;
        lsz      = beat_mode ? 16 : 8;
        offi     = int'(off);
        ni       = int'(n);
        fits80   = (offi + ni) < bsz;
        fitlen   = (bsz - offi - ni - 1) >= lsz;
        blk_full = (offi + 8) == bsz;
        for (int k = 0; k < 8; k++) begin
            dbyte[k] = s_axis_tdata[8*k +: 8];
            lbyte[k] = new_len[8*(7-k) +: 8];
        end
        for (int i = 0; i < NB; i++) begin
            nxt_blk[i] = blk[i];
            if (!s_axis_tlast) begin
                if (i >= offi && i < offi + 8) nxt_blk[i] = dbyte[3'(i - offi)];
            end else begin
                if (i >= offi) begin
                    if (i < offi + ni)       nxt_blk[i] = dbyte[3'(i - offi)];
                    else if (i == offi + ni) nxt_blk[i] = 8'h80;
                    else                     nxt_blk[i] = 8'h00;
                end
                if (fitlen && i >= bsz - 8 && i < bsz) nxt_blk[i] = lbyte[3'(i - (bsz - 8))];
            end
        end
    end

    // trailing length-only block used when the length did not fit after the data
    always_comb begin
        xbsz = mode_r ? 128 : 64;
        for (int k = 0; k < 8; k++) xlbyte[k] = bit_cnt[8*(7-k) +: 8];
        for (int i = 0; i < NB; i++) begin
            xtr_blk[i] = (i == 0 && pad80) ? 8'h80 : 8'h00;
            if (i >= xbsz - 8 && i < xbsz) xtr_blk[i] = xlbyte[3'(i - (xbsz - 8))];
        end
    end

    // big-endian packing: block byte 0 lands in the top byte of the active width
    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < 64; i++) begin
            if (!mode_r) m_axis_tdata[511-8*i -: 8] = blk[i];
        end
`ifdef SHA_PADDER_SHA512_EN
        for (int i = 0; i < 128; i++) begin
            if (mode_r) m_axis_tdata[1023-8*i -: 8] = blk[i];
        end
`endif
    end

    // FILL/EMIT/EXTRA sequencing, byte offset and message bit counter
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state   <= FILL;
            off     <= 8'd0;
            bit_cnt <= 64'd0;
            extra   <= 1'b0;
            pad80   <= 1'b0;
            in_msg  <= 1'b0;
            mode_r  <= 1'b0;
            tlast_r <= 1'b0;
            for (int i = 0; i < NB; i++) blk[i] <= 8'h00;
        end else begin
            case (state)
                FILL: begin
                    if (s_axis_tvalid) begin
                        for (int i = 0; i < NB; i++) blk[i] <= nxt_blk[i];
                        bit_cnt <= new_len;
                        mode_r  <= beat_mode;
                        in_msg  <= 1'b1;
                        if (s_axis_tlast) begin
                            state   <= EMIT;
                            tlast_r <= fitlen;
                            extra   <= !fitlen;
                            pad80   <= !fits80;
                        end else if (blk_full) begin
                            state   <= EMIT;
                            tlast_r <= 1'b0;
                        end else begin
                            off <= off + 8'd8;
                        end
                    end
                end
                EMIT: begin
                    if (m_axis_tready) begin
                        off     <= 8'd0;
                        tlast_r <= 1'b0;
                        if (extra) begin
                            state <= EXTRA;
                        end else begin
                            state <= FILL;
                            if (tlast_r) begin
                                bit_cnt <= 64'd0;
                                in_msg  <= 1'b0;
                            end
                        end
                    end
                end
                EXTRA: begin
                    for (int i = 0; i < NB; i++) blk[i] <= xtr_blk[i];
                    extra   <= 1'b0;
                    tlast_r <= 1'b1;
                    state   <= EMIT;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_padder.sv
// tb/tb_sha_padder.sv - self-checking bench for sha_padder against a queue-based padding model
module tb_sha_padder;

    logic          axi_aclk = 1'b0;
    logic          reset;
    logic [1:0]    sha_type;
    logic [63:0]   s_axis_tdata;
    logic [7:0]    s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [1023:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    int total = 0;
    int bad   = 0;

    logic [1024:0] exp_q[$];
    logic [1023:0] got_q[$];

    sha_padder #(.S_AXIS_DATA_WIDTH(64), .M_AXIS_DATA_WIDTH(1024)) dut (
        .axi_aclk(axi_aclk), .reset(reset), .sha_type(sha_type),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit eff_mode(input logic [1:0] t);
`ifdef SHA_PADDER_SHA512_EN
        return t[1];
`else
        return 1'b0;
`endif
    endfunction

    // standard SHA-2 padding: msg || 0x80 || zeros || length, then cut into blocks
    task automatic build_exp(input byte unsigned msg[$], input bit m);
        int bsz = m ? 128 : 64;
        int l = m ? 16 : 8;
        byte unsigned p[$];
        longint unsigned bits;
        logic [1023:0] d;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() + l) % bsz != 0) p.push_back(8'h00);
        for (int j = l - 1; j >= 0; j--) p.push_back(j < 8 ? 8'(bits >> (8*j)) : 8'h00);
        for (int b = 0; b < p.size() / bsz; b++) begin
            d = '0;
            for (int i = 0; i < bsz; i++) d[(bsz-i)*8-1 -: 8] = p[b*bsz+i];
            exp_q.push_back({(b == p.size() / bsz - 1) ? 1'b1 : 1'b0, d});
        end
    endtask

    task automatic run_msg(input logic [1:0] typ, input byte unsigned msg[$], input bit empty_tail,
                           input int stall, input bit rnd);
        int len = msg.size();
        int nb, lastv, v, k, cyc, hold, bsz;
        bit m, exp_v_next, prev_stall, prev_last, acc;
        logic [1023:0] prev_d;
        logic [1024:0] e;
        m = eff_mode(typ);
        bsz = m ? 128 : 64;
        if (len > 0 && len % 8 == 0 && !empty_tail) begin nb = len / 8; lastv = 8; end
        else begin nb = len / 8 + 1; lastv = len % 8; end
        build_exp(msg, m);
        got_q.delete();
        k = 0; cyc = 0; hold = 0; exp_v_next = 0; prev_stall = 0; prev_last = 0; prev_d = '0;
        while ((k < nb || exp_q.size() > 0) && cyc < 3000) begin
            @(negedge axi_aclk);
            cyc++;
            if (exp_v_next) chk("latency", 1024'(m_axis_tvalid), 1024'(1));
            exp_v_next = 0;
            if (prev_stall) begin
                chk("hold_valid", 1024'(m_axis_tvalid), 1024'(1));
                chk("hold_data", m_axis_tdata, prev_d);
                chk("hold_last", 1024'(m_axis_tlast), 1024'(prev_last));
            end
            m_axis_tready = 1'b0;
            prev_stall = 0;
            if (m_axis_tvalid) begin
                chk("in_rdy_emit", 1024'(s_axis_tready), 1024'(0));
                if (exp_q.size() == 0) begin
                    chk("extra_blk", 1024'(m_axis_tvalid), 1024'(0));
                    m_axis_tready = 1'b1;
                end else begin
                    if (stall > 0) begin acc = (hold >= stall); hold++; end
                    else acc = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (acc) begin
                        e = exp_q.pop_front();
                        chk("blk_data", m_axis_tdata, e[1023:0]);
                        chk("blk_last", 1024'(m_axis_tlast), 1024'(e[1024]));
                        got_q.push_back(m_axis_tdata);
                        hold = 0;
                        m_axis_tready = 1'b1;
                    end else begin
                        prev_stall = 1;
                        prev_d = m_axis_tdata;
                        prev_last = m_axis_tlast;
                    end
                end
            end
            s_axis_tvalid = 1'b0;
            if (k < nb && s_axis_tready && (!rnd || $urandom_range(0, 3) != 0)) begin
                v = (k == nb - 1) ? lastv : 8;
                for (int b = 0; b < 8; b++)
                    s_axis_tdata[8*b +: 8] = (b < v) ? msg[8*k+b] : 8'($urandom);
                s_axis_tkeep  = 8'((16'd1 << v) - 16'd1);
                s_axis_tlast  = (k == nb - 1);
                sha_type      = (k == 0) ? typ : 2'($urandom);
                s_axis_tvalid = 1'b1;
                if (k == nb - 1 || ((k + 1) * 8) % bsz == 0) exp_v_next = 1;
                k++;
            end
        end
        chk("msg_done", 1024'(exp_q.size()), 1024'(0));
        exp_q.delete();
        @(negedge axi_aclk);
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_beats(input int nbeats);
        int w;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge axi_aclk);
            s_axis_tvalid = 1'b0;
            w = 0;
            while (!s_axis_tready && w < 50) begin @(negedge axi_aclk); w++; end
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = 1'b0;
            s_axis_tvalid = 1'b1;
        end
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge axi_aclk);
        reset = 1'b1;
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        chk("rst_in_rdy", 1024'(s_axis_tready), 1024'(0));
        chk("rst_valid", 1024'(m_axis_tvalid), 1024'(0));
        chk("rst_last", 1024'(m_axis_tlast), 1024'(0));
        chk("rst_data", m_axis_tdata, 1024'(0));
        reset = 1'b0;
        @(negedge axi_aclk);
        chk("post_rst_rdy", 1024'(s_axis_tready), 1024'(1));
    endtask

    initial begin
        byte unsigned msg[$];
        logic [1023:0] c;
        int seen;
        reset = 1'b1; sha_type = 2'b00; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(negedge axi_aclk);
        chk("rst_in_rdy", 1024'(s_axis_tready), 1024'(0));
        chk("rst_valid", 1024'(m_axis_tvalid), 1024'(0));
        chk("rst_last", 1024'(m_axis_tlast), 1024'(0));
        chk("rst_data", m_axis_tdata, 1024'(0));
        reset = 1'b0;
        @(negedge axi_aclk);
        chk("post_rst_rdy", 1024'(s_axis_tready), 1024'(1));

        // "abc" on SHA256
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(2'b01, msg, 1'b0, 0, 1'b0);
        c = '0; c[511:480] = 32'h61626380; c[63:0] = 64'h18;
        chk("abc_count", 1024'(got_q.size()), 1024'(1));
        chk("abc_block", got_q[0], c);

        // 56 zero bytes: 0x80 fits, length spills into a second block
        msg.delete();
        for (int i = 0; i < 56; i++) msg.push_back(8'h00);
        run_msg(2'b00, msg, 1'b0, 0, 1'b0);
        c = '0; c[63:56] = 8'h80;
        chk("z56_blk1", got_q[0], c);
        c = '0; c[63:0] = 64'h1C0;
        chk("z56_blk2", got_q[1], c);

        // 64 bytes: raw block then 0x80 + length block
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'(i + 1));
        run_msg(2'b01, msg, 1'b0, 0, 1'b0);
        c = '0; c[511:504] = 8'h80; c[63:0] = 64'h200;
        chk("b64_blk2", got_q[1], c);
        run_msg(2'b01, msg, 1'b1, 0, 1'b0);

        // empty message on SHA512 (512-bit block when the wide mode is not built)
        msg.delete();
        run_msg(2'b11, msg, 1'b1, 0, 1'b0);
        c = '0;
`ifdef SHA_PADDER_SHA512_EN
        c[1023:1016] = 8'h80;
`else
        c[511:504] = 8'h80;
`endif
        chk("empty_512", got_q[0], c);

        // output backpressure for 10 cycles per block
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(2'b01, msg, 1'b0, 10, 1'b0);
        msg.delete();
        for (int i = 0; i < 120; i++) msg.push_back(8'($urandom));
        run_msg(2'b10, msg, 1'b0, 10, 1'b0);

        // reset mid-message discards everything
        send_beats(3);
        do_reset();
        seen = 0;
        repeat (20) begin @(negedge axi_aclk); if (m_axis_tvalid) seen++; end
        chk("rst_mid_msg", 1024'(seen), 1024'(0));

        // reset mid-EMIT discards the pending block
        sha_type = 2'b00;
        send_beats(8);
        chk("emit_valid", 1024'(m_axis_tvalid), 1024'(1));
        do_reset();
        seen = 0;
        m_axis_tready = 1'b1;
        repeat (20) begin @(negedge axi_aclk); if (m_axis_tvalid) seen++; end
        m_axis_tready = 1'b0;
        chk("rst_mid_emit", 1024'(seen), 1024'(0));

        // a fresh message after reset must carry a length from zero
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(2'b00, msg, 1'b0, 0, 1'b0);
        c = '0; c[511:480] = 32'h61626380; c[63:0] = 64'h18;
        chk("post_rst_abc", got_q[0], c);

        // random lengths, modes, tails and handshake gaps
        for (int t = 0; t < 30; t++) begin
            msg.delete();
            for (int i = 0; i < int'($urandom_range(0, 300)); i++) msg.push_back(8'($urandom));
            run_msg(2'($urandom), msg, 1'($urandom), 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
